// File: rtl/conv_pkg.sv
// conv_pkg: constants shared by the 3x3 window generator and the conv MAC
// wrapper. Holds the default image geometry, the window size and the named
// window slot indices (slot = 3*row_offset + col_offset, TL = oldest corner,
// BR = newest pixel).
package conv_pkg;

    localparam int CONV_DATA_W = 16;
    localparam int CONV_IMG_W  = 28;
    localparam int CONV_IMG_H  = 28;

    localparam int WIN_K = 3;
    localparam int WIN_N = WIN_K * WIN_K;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: enable-gated delay line. dout_o always shows the value that
// was written DEPTH enables ago; nothing moves on cycles without en_i.
// Storage is a circular buffer (read-before-write at the same pointer), so it
// maps onto RAM or registers. Contents are not cleared by reset.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset (pointer only)
//   en_i    - advance the delay line by one entry
//   din_i   - value written on an enabled cycle
//   dout_o  - value written DEPTH enables earlier
module conv_line_buf #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d;

    assign dout_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator in front of the conv MAC.
// Accepts one raster-order pixel per handshake, keeps two line buffers and a
// 3x3 window register, and presents a window whenever the accepted pixel
// completes an unpadded neighbourhood (row >= 2 and col >= 2).
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   pix_in/pix_valid  - incoming pixel stream; pix_ready = !win_valid || win_ready
//   win0..win8        - window, slot = 3*dr + dc (win0 top-left, win8 newest)
//   win_valid         - window outputs valid, held stable until win_ready
//   win_ready         - downstream takes the window
//   win_last          - only when WIN_LAST_EN is defined: marks the last
//                       window of the frame
//
// Build option: define WIN_LAST_EN to add the win_last output.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = CONV_IMG_W,
    parameter int IMG_H  = CONV_IMG_H,
    parameter int DATA_W = CONV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] win0,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic              win_valid,
    input  logic              win_ready
`ifdef WIN_LAST_EN
    ,
    output logic              win_last
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] win_q [WIN_N];
    logic [DATA_W-1:0] win_d [WIN_N];
    logic              win_valid_q, win_valid_d;
    logic [DATA_W-1:0] lb1_out, lb2_out;
    logic              accept, emit, col_end, row_end;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = (col_q == CW'(IMG_W - 1));
    assign row_end   = (row_q == RW'(IMG_H - 1));
    // Position of the pixel being accepted; windows that would straddle a
    // row wrap or reach above row 0 are suppressed here.
    assign emit      = (row_q >= RW'(2)) && (col_q >= CW'(2));

    conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .din_i  (pix_in),
        .dout_o (lb1_out)
    );

    conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .din_i  (lb1_out),
        .dout_o (lb2_out)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        if (accept) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            if (col_end) begin
                row_d = row_end ? '0 : row_q + 1'b1;
            end
            for (int r = 0; r < WIN_K; r++) begin
                for (int c = 0; c < WIN_K - 1; c++) begin
                    win_d[r*WIN_K + c] = win_q[r*WIN_K + c + 1];
                end
            end
            win_d[WIN_TR] = lb2_out;
            win_d[WIN_MR] = lb1_out;
            win_d[WIN_BR] = pix_in;
            // An accept implies any held window is being taken this cycle,
            // so the new window (if any) replaces it with no bubble.
            win_valid_d = emit;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '{default: '0};
            win_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
        end
    end

`ifdef WIN_LAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = emit && row_end && col_end;
        end else if (win_ready) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign win_last = last_q;
`endif

    assign win0      = win_q[WIN_TL];
    assign win1      = win_q[WIN_TC];
    assign win2      = win_q[WIN_TR];
    assign win3      = win_q[WIN_ML];
    assign win4      = win_q[WIN_MC];
    assign win5      = win_q[WIN_MR];
    assign win6      = win_q[WIN_BL];
    assign win7      = win_q[WIN_BC];
    assign win8      = win_q[WIN_BR];
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;
`ifdef WIN_LAST_EN
    localparam bit WL = 1'b1;
`else
    localparam bit WL = 1'b0;
`endif

    typedef struct packed {
        logic                last;
        logic [8:0][DW-1:0]  w;
    } win_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic [8:0][DW-1:0] cur_w;

    win_t    exp_q[$];
    win_t    obs_q[$];
    win_t    e_m;
    logic [DW-1:0] img [H][W];
    int      mr = 0, mc = 0;
    int      total = 0, bad = 0;
    int      cyc = 0;
    bit      rnd_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur_w = {win8, win7, win6, win5, win4, win3, win2, win1, win0};
`ifndef WIN_LAST_EN
    assign win_last = 1'b0;
`endif

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win0      (win0),
        .win1      (win1),
        .win2      (win2),
        .win3      (win3),
        .win4      (win4),
        .win5      (win5),
        .win6      (win6),
        .win7      (win7),
        .win8      (win8),
        .win_valid (win_valid),
        .win_ready (win_ready)
`ifdef WIN_LAST_EN
        ,
        .win_last  (win_last)
`endif
    );

    // Reference: store each accepted pixel at its raster position and, when
    // it completes a neighbourhood, cut the expected window out of the image.
    always @(negedge clk) begin
        if (rst) begin
            mr = 0;
            mc = 0;
        end else begin
            if (pix_valid && pix_ready) begin
                img[mr][mc] = pix_in;
                if (mr >= 2 && mc >= 2) begin
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            e_m.w[3*dr + dc] = img[mr-2+dr][mc-2+dc];
                    e_m.last = WL && (mr == H-1) && (mc == W-1);
                    exp_q.push_back(e_m);
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr++;
                    if (mr == H) mr = 0;
                end
            end
            if (win_valid && win_ready) obs_q.push_back({win_last, cur_w});
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push_pix(input logic [DW-1:0] v, input int bub);
        int guard = 0;
        while ($urandom_range(99) < bub) begin
            pix_valid = 1'b0;
            if (rnd_rdy) win_ready = 1'($urandom_range(1));
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_in = v;
        if (rnd_rdy) win_ready = 1'($urandom_range(1));
        @(negedge clk);
        while (!pix_ready && guard < 64) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) win_ready = 1'($urandom_range(1));
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: pix_ready=%0b after %0d cycles, want 1", pix_ready, guard);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic send_frame(input int base, input int bub, input bit rnd_val);
        for (int i = 0; i < W*H; i++)
            push_pix(rnd_val ? DW'($urandom) : DW'(base + i), bub);
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (win_valid !== 1'b0) begin bad++; $display("FAIL reset_win_valid: got %b want 0", win_valid); end
            total++;
            if (pix_ready !== 1'b1) begin bad++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
            total++;
            if (cur_w !== '0) begin bad++; $display("FAIL reset_win_data: got %h want 0", cur_w); end
            total++;
            if (win_last !== 1'b0) begin bad++; $display("FAIL reset_win_last: got %b want 0", win_last); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        logic [8:0][DW-1:0] k;
        int ends [4] = '{10, 11, 14, 15};
        do_reset();
        for (int i = 0; i < 10; i++) push_pix(DW'(i), 0);
        @(negedge clk);
        total++;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL early_window: win_valid=%b want 0", win_valid); end
        @(posedge clk);
        #1;
        push_pix(DW'(10), 0);
        @(negedge clk);
        for (int i = 0; i < 9; i++) k[i] = DW'(4*(i/3) + (i%3));
        total++;
        if (win_valid !== 1'b1) begin bad++; $display("FAIL first_latency: win_valid=%b want 1", win_valid); end
        total++;
        if (cur_w !== k) begin bad++; $display("FAIL first_window: got %h want %h", cur_w, k); end
        @(posedge clk);
        #1;
        for (int i = 11; i < 16; i++) push_pix(DW'(i), 0);
        repeat (4) @(negedge clk);
        total++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL full_count: got %0d windows, model %0d, want 4", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            total++;
            if (obs_q[i].w[8] !== DW'(ends[i])) begin bad++; $display("FAIL full_end%0d: got %0d want %0d", i, obs_q[i].w[8], ends[i]); end
        end
    endtask

    task automatic test_bubbles();
        do_reset();
        send_frame(0, 50, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL bubble_count: got %0d windows, model %0d, want 4", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bubble_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0][DW-1:0] k;
        do_reset();
        for (int i = 0; i < 12; i++) push_pix(DW'(i), 0);
        win_ready = 1'b0;
        pix_valid = 1'b1;
        pix_in = DW'(12);
        for (int i = 0; i < 9; i++) k[i] = DW'(4*(i/3) + (i%3) + 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (pix_ready !== 1'b0) begin bad++; $display("FAIL stall_pix_ready%0d: got %b want 0", c, pix_ready); end
            total++;
            if (win_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d: got %b want 1", c, win_valid); end
            total++;
            if (cur_w !== k) begin bad++; $display("FAIL stall_data%0d: got %h want %h", c, cur_w, k); end
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
        for (int i = 12; i < 16; i++) push_pix(DW'(i), 0);
        repeat (4) @(negedge clk);
        total++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL stall_count: got %0d windows, model %0d, want 4", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0][DW-1:0] k;
        int c0;
        do_reset();
        c0 = cyc;
        send_frame(0, 0, 1'b0);
        send_frame(16, 0, 1'b0);
        total++;
        if (cyc - c0 != 32) begin bad++; $display("FAIL throughput: got %0d cycles for 32 pixels want 32", cyc - c0); end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 9; i++) k[i] = DW'(16 + 4*(i/3) + (i%3));
        total++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got %0d windows, model %0d, want 8", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            total++;
            if (obs_q[i].last !== (WL && (i == 3 || i == 7))) begin
                bad++;
                $display("FAIL b2b_last%0d: got %b want %b", i, obs_q[i].last, (WL && (i == 3 || i == 7)));
            end
        end
        if (obs_q.size() > 4) begin
            total++;
            if (obs_q[4].w !== k) begin bad++; $display("FAIL b2b_fifth: got %h want %h", obs_q[4].w, k); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) push_pix(DW'(i), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (win_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", win_valid); end
        @(posedge clk);
        #1;
        send_frame(0, 0, 1'b0);
        repeat (4) @(negedge clk);
        total++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            bad++;
            $display("FAIL midrst_count: got %0d windows, model %0d, want 4", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        rnd_rdy = 1'b1;
        send_frame(0, 30, 1'b1);
        send_frame(0, 30, 1'b1);
        rnd_rdy = 1'b0;
        win_ready = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            bad++;
            $display("FAIL rand_count: got %0d windows, model %0d, want 8", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_win%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_in = '0;
        win_ready = 1'b1;
        test_reset();
        test_full_frame();
        test_bubbles();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
